// File: rtl/vga_timing_ctrl_if.sv
// Frame-buffer fetch bus between the VGA timing controller and the pixel store.
// The controller is the master: it issues one-HCLK read strobes with a column/row
// address, and the frame buffer answers on PIXEL_IN by the following pixel tick.
interface vga_timing_ctrl_if;
  logic       FETCH_REQ;
  logic [9:0] FETCH_X;
  logic [8:0] FETCH_Y;
  logic [7:0] PIXEL_IN;

  modport master (output FETCH_REQ, output FETCH_X, output FETCH_Y, input PIXEL_IN);
  modport slave  (input FETCH_REQ, input FETCH_X, input FETCH_Y, output PIXEL_IN);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: generates HSYNC/VSYNC from a pixel tick of HCLK/2,
// issues one frame-buffer fetch per visible pixel and drives RGB to the pins.
// Sync and RGB share a two-tick pipeline from the counter position so they stay
// aligned at the connector.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              ENABLE,
  vga_timing_ctrl_if.master fb,
  output logic [7:0]        RGB,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_tog;
  logic [9:0] r_hCnt;
  logic [9:0] r_vCnt;
  logic       r_d1Vis;
  logic       r_d1Hs;
  logic       r_d1Vs;
  logic       r_d1Org;

  logic w_tick;
  logic w_active;
  logic w_visible;
  logic w_hsLow;
  logic w_vsLow;
  logic w_origin;
  logic w_lineEnd;
  logic w_frameEnd;

  assign w_tick     = ~r_tog;
  assign w_active   = (r_state != IDLE);
  assign w_visible  = (r_hCnt < H_VIS_END) && (r_vCnt < V_VIS_END);
  assign w_hsLow    = (r_hCnt >= H_SYNC_LO) && (r_hCnt < H_SYNC_HI);
  assign w_vsLow    = (r_vCnt >= V_SYNC_LO) && (r_vCnt < V_SYNC_HI);
  assign w_origin   = (r_hCnt == 10'd0) && (r_vCnt == 10'd0);
  assign w_lineEnd  = (r_hCnt == H_LAST);
  assign w_frameEnd = w_lineEnd && (r_vCnt == V_LAST);
  assign BUSY       = w_active;

  // Pixel tick divider: the tick is the HCLK edge where the toggle rises.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_tog <= 1'b0;
    else          r_tog <= ~r_tog;
  end

  // Run/drain sequencing; a drain only stops at the very last position of a frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (ENABLE) w_nextState = RUN;
      RUN:     if (!ENABLE) w_nextState = DRAIN;
      DRAIN: begin
        if (ENABLE)          w_nextState = RUN;
        else if (w_frameEnd) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, advanced on pixel ticks only so ENABLE is sampled per tick.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    r_state <= IDLE;
    else if (w_tick) r_state <= w_nextState;
  end

  // Raster counters; held at the origin while idle so a restart begins at (0,0).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hCnt <= 10'd0;
      r_vCnt <= 10'd0;
    end else if (w_tick) begin
      if (!w_active) begin
        r_hCnt <= 10'd0;
        r_vCnt <= 10'd0;
      end else if (w_lineEnd) begin
        r_hCnt <= 10'd0;
        r_vCnt <= w_frameEnd ? 10'd0 : r_vCnt + 10'd1;
      end else begin
        r_hCnt <= r_hCnt + 10'd1;
      end
    end
  end

  // Fetch strobe lasts exactly the HCLK after a visible tick; the address holds between strobes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fb.FETCH_REQ <= 1'b0;
      fb.FETCH_X   <= 10'd0;
      fb.FETCH_Y   <= 9'd0;
    end else if (w_tick && w_active && w_visible) begin
      fb.FETCH_REQ <= 1'b1;
      fb.FETCH_X   <= r_hCnt;
      fb.FETCH_Y   <= r_vCnt[8:0];
    end else begin
      fb.FETCH_REQ <= 1'b0;
    end
  end

  // First pipeline stage: position attributes travel alongside the outstanding fetch.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_d1Vis <= 1'b0;
      r_d1Hs  <= 1'b1;
      r_d1Vs  <= 1'b1;
      r_d1Org <= 1'b0;
    end else if (w_tick) begin
      if (!w_active) begin
        r_d1Vis <= 1'b0;
        r_d1Hs  <= 1'b1;
        r_d1Vs  <= 1'b1;
        r_d1Org <= 1'b0;
      end else begin
        r_d1Vis <= w_visible;
        r_d1Hs  <= ~w_hsLow;
        r_d1Vs  <= ~w_vsLow;
        r_d1Org <= w_origin;
      end
    end
  end

  // Pin stage: pixel data meets its sync values here; FRAME_START is a single-HCLK pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      RGB         <= 8'h00;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      FRAME_START <= 1'b0;
    end else if (w_tick) begin
      if (!w_active) begin
        RGB         <= 8'h00;
        HSYNC       <= 1'b1;
        VSYNC       <= 1'b1;
        FRAME_START <= 1'b0;
      end else begin
        RGB         <= r_d1Vis ? fb.PIXEL_IN : 8'h00;
        HSYNC       <= r_d1Hs;
        VSYNC       <= r_d1Vs;
        FRAME_START <= r_d1Org;
      end
    end else begin
      FRAME_START <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl using a shrunken raster so several frames fit in a
// short run. A position-index reference model predicts the pins for every pixel
// tick and queues the prediction; an independent monitor pops and compares.
module tb_vga_timing_ctrl;

  localparam int H_VIS = 8;
  localparam int H_FP  = 2;
  localparam int H_SW  = 3;
  localparam int H_BP  = 2;
  localparam int V_VIS = 4;
  localparam int V_FP  = 1;
  localparam int V_SW  = 2;
  localparam int V_BP  = 1;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int FRAME_TICKS = H_TOT * V_TOT;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct {
    logic       busy;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       freq;
    logic [9:0] fx;
    logic [8:0] fy;
  } expRec_t;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b1;
  logic       ENABLE  = 1'b0;
  logic [7:0] RGB;
  logic       HSYNC;
  logic       VSYNC;
  logic       FRAME_START;
  logic       BUSY;

  logic       tbTog;
  bit         monOn     = 1'b0;
  bit         benchDone = 1'b0;
  int         nCompared   = 0;
  int         nMismatched = 0;
  int         pixSeed;
  logic       curEn;

  expRec_t    expQ[$];

  int         mMode;
  int         mPos;
  int         mPrev;
  logic [9:0] mFx;
  logic [8:0] mFy;

  vga_timing_ctrl_if fbIf ();

  vga_timing_ctrl #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ENABLE      (ENABLE),
    .fb          (fbIf.master),
    .RGB         (RGB),
    .HSYNC       (HSYNC),
    .VSYNC       (VSYNC),
    .FRAME_START (FRAME_START),
    .BUSY        (BUSY)
  );

  initial forever #5 HCLK = ~HCLK;

  // Tick phase seen from the bench: inverts every HCLK from 0 after reset.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tbTog <= 1'b0;
    else          tbTog <= ~tbTog;
  end

  function automatic logic [7:0] pixOf(input int x, input int y);
    return 8'((x * 3 + y * 29) ^ pixSeed);
  endfunction

  function automatic bit isVisible(input int h, input int v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  // Frame buffer: answers each strobe by the next tick; junk otherwise.
  initial begin
    fbIf.PIXEL_IN = 8'h00;
    forever begin
      @(negedge HCLK);
      if (HRESETn && tbTog) begin
        if (fbIf.FETCH_REQ) fbIf.PIXEL_IN = pixOf(int'(fbIf.FETCH_X), int'(fbIf.FETCH_Y));
        else                fbIf.PIXEL_IN = 8'($urandom);
      end
    end
  end

  task automatic modelReset();
    mMode = M_IDLE;
    mPos  = 0;
    mPrev = -1;
    mFx   = 10'd0;
    mFy   = 9'd0;
  endtask

  // One pixel tick of the reference: positions are a flat index into the frame.
  task automatic modelTick(input logic e);
    expRec_t r;
    int h;
    int v;
    r.rgb  = 8'h00;
    r.hs   = 1'b1;
    r.vs   = 1'b1;
    r.fs   = 1'b0;
    r.freq = 1'b0;
    if (mMode == M_IDLE) begin
      mPrev = -1;
      if (e) begin
        mMode = M_RUN;
        mPos  = 0;
      end
    end else begin
      if (mPrev >= 0) begin
        h    = mPrev % H_TOT;
        v    = mPrev / H_TOT;
        r.rgb = isVisible(h, v) ? pixOf(h, v) : 8'h00;
        r.hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SW));
        r.vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SW));
        r.fs  = (mPrev == 0);
      end
      h = mPos % H_TOT;
      v = mPos / H_TOT;
      if (isVisible(h, v)) begin
        r.freq = 1'b1;
        mFx    = 10'(h);
        mFy    = 9'(v);
      end
      mPrev = mPos;
      if (e)                         mMode = M_RUN;
      else if (mMode == M_RUN)       mMode = M_DRAIN;
      else if (mPos == FRAME_TICKS - 1) mMode = M_IDLE;
      mPos = (mPos + 1) % FRAME_TICKS;
    end
    r.busy = (mMode != M_IDLE);
    r.fx   = mFx;
    r.fy   = mFy;
    expQ.push_back(r);
  endtask

  // Entered just before a tick edge; pat 0 holds lvl, pat 1 flips ENABLE at random.
  // ENABLE is also scrambled between ticks, where it must be ignored.
  task automatic applyStimulus(input int nTicks, input int pat, input logic lvl);
    for (int k = 0; k < nTicks; k++) begin
      logic e;
      if (pat == 0) begin
        e = lvl;
      end else begin
        if ($urandom_range(0, 39) == 0) curEn = ~curEn;
        e = curEn;
      end
      ENABLE = e;
      modelTick(e);
      @(negedge HCLK);
      ENABLE = 1'($urandom_range(0, 1));
      @(negedge HCLK);
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input expRec_t r);
    check("busy",        16'(BUSY),           16'(r.busy));
    check("rgb",         16'(RGB),            16'(r.rgb));
    check("hsync",       16'(HSYNC),          16'(r.hs));
    check("vsync",       16'(VSYNC),          16'(r.vs));
    check("frame_start", 16'(FRAME_START),    16'(r.fs));
    check("fetch_req",   16'(fbIf.FETCH_REQ), 16'(r.freq));
    check("fetch_x",     16'(fbIf.FETCH_X),   16'(r.fx));
    check("fetch_y",     16'(fbIf.FETCH_Y),   16'(r.fy));
  endtask

  task automatic checkReset();
    check("rst_rgb",     16'(RGB),            16'h0000);
    check("rst_hsync",   16'(HSYNC),          16'h0001);
    check("rst_vsync",   16'(VSYNC),          16'h0001);
    check("rst_busy",    16'(BUSY),           16'h0000);
    check("rst_fs",      16'(FRAME_START),    16'h0000);
    check("rst_freq",    16'(fbIf.FETCH_REQ), 16'h0000);
    check("rst_fetch_x", 16'(fbIf.FETCH_X),   16'h0000);
    check("rst_fetch_y", 16'(fbIf.FETCH_Y),   16'h0000);
  endtask

  // Monitor: checks reset values, pops one prediction per tick, and checks the
  // strobes stay low in the HCLK between ticks.
  initial begin
    forever begin
      @(negedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        expQ.delete();
        #1;
        checkReset();
      end else if (benchDone) begin
        check("queue_drained", 16'(expQ.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
      end else if (monOn) begin
        if (tbTog) begin
          if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboard: got no prediction, required one at t=%0t", $time);
          end else begin
            checkOutput(expQ.pop_front());
          end
        end else begin
          check("freq_width", 16'(fbIf.FETCH_REQ), 16'h0000);
          check("fs_width",   16'(FRAME_START),    16'h0000);
        end
      end
    end
  end

  initial begin
    pixSeed = int'($urandom);
    curEn   = 1'b1;
    modelReset();
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    monOn = 1'b1;
    $display("[TB] reset released, starting raster run");

    applyStimulus(5,   0, 1'b0);
    applyStimulus(300, 0, 1'b1);
    applyStimulus(260, 0, 1'b0);
    applyStimulus(40,  0, 1'b1);
    applyStimulus(30,  0, 1'b0);
    applyStimulus(300, 0, 1'b1);
    applyStimulus(200, 0, 1'b0);
    applyStimulus(2000, 1, 1'b0);

    applyStimulus(157, 0, 1'b1);
    $display("[TB] asserting reset mid-line");
    #2;
    monOn   = 1'b0;
    HRESETn = 1'b0;
    modelReset();
    repeat (2) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    monOn = 1'b1;

    applyStimulus(300, 0, 1'b1);
    curEn = 1'b0;
    applyStimulus(300, 1, 1'b0);
    applyStimulus(150, 0, 1'b0);

    benchDone = 1'b1;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the VGA display datapath. It generates the 640x480 sync timing from HCLK and issues one frame-buffer fetch per visible pixel. It drives RGB, HSYNC and VSYNC to the pins, blanking RGB outside the active area. It sits between the AHB-side frame buffer and the VGA output pins, one pixel tick = two HCLK cycles.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, HSYNC low width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, VSYNC low width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
ENABLE  in  1  run request, level-sensitive
PIXEL_IN  in  8  frame-buffer read data, valid one tick after FETCH_REQ
FETCH_REQ  out  1  frame-buffer read strobe, one HCLK wide, on pixel tick
FETCH_X  out  10  column of requested pixel, 0..639
FETCH_Y  out  9  row of requested pixel, 0..479
RGB  out  8  pixel to pins, 0 when blanked
HSYNC  out  1  horizontal sync, active low
VSYNC  out  1  vertical sync, active low
FRAME_START  out  1  one-HCLK pulse on first tick of line 0
BUSY  out  1  high in RUN or DRAIN

Behaviour:
- Reset: tick toggle=0, h_cnt=0, v_cnt=0, state=IDLE, RGB=0, HSYNC=1, VSYNC=1, FETCH_REQ=0, FETCH_X=0, FETCH_Y=0, FRAME_START=0, BUSY=0.
- Pixel tick: the internal toggle inverts every HCLK. Tick = HCLK where the toggle goes 0->1. All counter and output updates happen only on ticks.
- Line = 800 ticks; h_cnt wraps 799->0 and increments v_cnt. Frame = 525 lines; v_cnt wraps 524->0.
- Visible area: h_cnt<640 and v_cnt<480.
- Sync (pre-pipeline): HSYNC low for h_cnt in 656..751. VSYNC low for v_cnt in 490..491.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0, outputs at reset values. ENABLE=1 -> RUN on next tick, starting at h_cnt=0, v_cnt=0.
  - RUN: counters advance. ENABLE=0 -> DRAIN.
  - DRAIN: continues normally to the end of the current frame (h=799, v=524), then -> IDLE. If ENABLE returns to 1 during DRAIN -> RUN without interruption.
- Fetch:
  - On a tick with the current position visible and state RUN/DRAIN: FETCH_REQ=1 for that HCLK, FETCH_X=h_cnt, FETCH_Y=v_cnt[8:0].
  - FETCH_X/FETCH_Y hold their last values between requests.
- Pipeline: PIXEL_IN is sampled on the tick after the request. RGB, HSYNC and VSYNC are all registered with an identical 2-tick delay from the counter position, so sync and pixels stay mutually aligned.
  - RGB = sampled PIXEL_IN when the delayed position was visible, else 8'h00.
- FRAME_START pulses on the tick where the delayed position is (0,0).
- IDLE->RUN entry: the pipeline is flushed to blank/sync-high values.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).
- ENABLE is sampled only on ticks.

Test Plan:
- Reset: assert HRESETn=0 mid-line -> RGB=0, HSYNC=VSYNC=1, BUSY=0 within the same HCLK cycle; counters restart at (0,0) after ENABLE.
- Line timing: ENABLE=1 -> HSYNC low 192 HCLK, period 1600 HCLK; first HSYNC fall at 2*(656+2) HCLK after the first tick.
- Frame timing: VSYNC low 3200 HCLK every 840000 HCLK; exactly 525 HSYNC falls between consecutive VSYNC falls; FRAME_START once per frame.
- Pixel path: frame-buffer model returns 8'h1c at 1 tick -> per line exactly 640 ticks of RGB=8'h1c, 160 ticks of 0; lines 480..524 all 0; 307200 FETCH_REQ per frame.
- Address sweep: model returns FETCH_X[7:0] -> RGB sequence 0x00,0x01..0xFF,0x00.. per line; FETCH_Y reaches 479, never 480.
- Stop/restart: drop ENABLE at v=100 -> frame completes, BUSY falls after the v=524 line, outputs idle. Reassert ENABLE during DRAIN -> no gap in HSYNC period.
